// File: rtl/coin_acceptor.sv
// coin_acceptor: optical coin-slot pulse decoder feeding the vending FSM.
// Ports: clk, rst (async low), sensor (raw), en -> coin[4:0], reject, jam, busy.
module coin_acceptor #(
    parameter int CNT_W     = 8,
    parameter int T5_MIN    = 4,
    parameter int T5_MAX    = 8,
    parameter int T10_MIN   = 12,
    parameter int T10_MAX   = 20,
    parameter int JAM_LIMIT = 100,
    parameter int GAP       = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sensor,
    input  logic       en,
    output logic [4:0] coin,
    output logic       reject,
    output logic       jam,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEASURE,
        S_JAM,
        S_LOCKOUT
    } state_t;

    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam logic [CNT_W-1:0] T5LO_C  = CNT_W'(T5_MIN);
    localparam logic [CNT_W-1:0] T5HI_C  = CNT_W'(T5_MAX);
    localparam logic [CNT_W-1:0] T10LO_C = CNT_W'(T10_MIN);
    localparam logic [CNT_W-1:0] T10HI_C = CNT_W'(T10_MAX);
    localparam logic [CNT_W-1:0] JAM_C   = CNT_W'(JAM_LIMIT);
    localparam logic [CNT_W-1:0] GAP_C   = CNT_W'(GAP);

    state_t           state_q;
    logic             sync1_q;
    logic             s_q;
    logic [CNT_W-1:0] cnt_q;
    logic             en_q;
    logic [4:0]       coin_q;
    logic             reject_q;
    logic             jam_q;
    logic             busy_q;

    logic [CNT_W-1:0] cnt_inc;
    logic             in5;
    logic             in10;

    // Saturating increment: the counter never wraps.
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    assign in5     = (cnt_q >= T5LO_C) && (cnt_q <= T5HI_C);
    assign in10    = (cnt_q >= T10LO_C) && (cnt_q <= T10HI_C);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q  <= 1'b0;
            s_q      <= 1'b0;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            en_q     <= 1'b0;
            coin_q   <= '0;
            reject_q <= 1'b0;
            jam_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            sync1_q  <= sensor;
            s_q      <= sync1_q;
            coin_q   <= '0;
            reject_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (s_q) begin
                        state_q <= S_MEASURE;
                        cnt_q   <= ONE_C;
                        en_q    <= en;
                        busy_q  <= 1'b1;
                    end
                end
                S_MEASURE: begin
                    if (s_q) begin
                        cnt_q <= cnt_inc;
                        if (cnt_inc == JAM_C) begin
                            state_q <= S_JAM;
                            jam_q   <= 1'b1;
                        end
                    end else begin
                        // Falling edge of s: classify the width just measured.
                        state_q <= S_LOCKOUT;
                        cnt_q   <= '0;
                        if (!en_q) begin
                            reject_q <= 1'b1;
                        end else if (in5) begin
                            coin_q <= 5'd5;
                        end else if (in10) begin
                            coin_q <= 5'd10;
                        end else begin
                            reject_q <= 1'b1;
                        end
                    end
                end
                S_JAM: begin
                    if (!s_q) begin
                        state_q  <= S_LOCKOUT;
                        cnt_q    <= '0;
                        jam_q    <= 1'b0;
                        reject_q <= 1'b1;
                    end
                end
                S_LOCKOUT: begin
                    // cnt holds the run of consecutive lows; any high restarts it.
                    if (cnt_q >= GAP_C) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (s_q) begin
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    jam_q   <= 1'b0;
                end
            endcase
        end
    end

    assign coin   = coin_q;
    assign reject = reject_q;
    assign jam    = jam_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// tb_coin_acceptor: directed vector bench for coin_acceptor.
// Table of pulse widths plus hand-timed latency, jam, bounce and reset cases.
module tb_coin_acceptor;

    logic       clk;
    logic       rst;
    logic       sensor;
    logic       en;
    logic [4:0] coin;
    logic       reject;
    logic       jam;
    logic       busy;

    int checks = 0;
    int errors = 0;

    int n_coin   = 0;
    int coin_sum = 0;
    int n_rej    = 0;
    int n_jam    = 0;
    int n_excl   = 0;
    int n_bad    = 0;

    typedef struct {
        int   width;
        logic en0;
        logic en1;
        int   exp_ncoin;
        int   exp_sum;
        int   exp_nrej;
    } vec_t;

    vec_t vecs[16];

    coin_acceptor dut (
        .clk    (clk),
        .rst    (rst),
        .sensor (sensor),
        .en     (en),
        .coin   (coin),
        .reject (reject),
        .jam    (jam),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst) begin
            if (coin != 5'd0) begin
                n_coin   = n_coin + 1;
                coin_sum = coin_sum + int'(coin);
            end
            if (reject) n_rej = n_rej + 1;
            if (jam) n_jam = n_jam + 1;
            if (coin != 5'd0 && reject) n_excl = n_excl + 1;
            if (!(coin inside {5'd0, 5'd5, 5'd10})) n_bad = n_bad + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: act=%0d req=%0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx);
        int c0, s0, r0, j0;
        c0 = n_coin;
        s0 = coin_sum;
        r0 = n_rej;
        j0 = n_jam;
        en = vecs[idx].en0;
        sensor = 1'b1;
        for (int i = 1; i <= vecs[idx].width; i++) begin
            tick();
            if (i == 3) en = vecs[idx].en1;
        end
        sensor = 1'b0;
        repeat (14) tick();
        chk($sformatf("v%0d_ncoin", idx), n_coin - c0, vecs[idx].exp_ncoin);
        chk($sformatf("v%0d_sum", idx), coin_sum - s0, vecs[idx].exp_sum);
        chk($sformatf("v%0d_nrej", idx), n_rej - r0, vecs[idx].exp_nrej);
        chk($sformatf("v%0d_jam", idx), n_jam - j0, 0);
        chk($sformatf("v%0d_busy", idx), int'(busy), 0);
    endtask

    initial begin
        int c0, s0, r0;
        vecs[0]  = '{6,  1'b1, 1'b1, 1, 5,  0};
        vecs[1]  = '{15, 1'b1, 1'b1, 1, 10, 0};
        vecs[2]  = '{12, 1'b1, 1'b1, 1, 10, 0};
        vecs[3]  = '{20, 1'b1, 1'b1, 1, 10, 0};
        vecs[4]  = '{2,  1'b1, 1'b1, 0, 0,  1};
        vecs[5]  = '{10, 1'b1, 1'b1, 0, 0,  1};
        vecs[6]  = '{25, 1'b1, 1'b1, 0, 0,  1};
        vecs[7]  = '{4,  1'b1, 1'b1, 1, 5,  0};
        vecs[8]  = '{8,  1'b1, 1'b1, 1, 5,  0};
        vecs[9]  = '{3,  1'b1, 1'b1, 0, 0,  1};
        vecs[10] = '{9,  1'b1, 1'b1, 0, 0,  1};
        vecs[11] = '{11, 1'b1, 1'b1, 0, 0,  1};
        vecs[12] = '{21, 1'b1, 1'b1, 0, 0,  1};
        vecs[13] = '{1,  1'b1, 1'b1, 0, 0,  1};
        vecs[14] = '{6,  1'b0, 1'b1, 0, 0,  1};
        vecs[15] = '{6,  1'b1, 1'b0, 1, 5,  0};

        rst = 1'b0;
        sensor = 1'b0;
        en = 1'b0;
        #3;
        chk("rst_coin", int'(coin), 0);
        chk("rst_reject", int'(reject), 0);
        chk("rst_jam", int'(jam), 0);
        chk("rst_busy", int'(busy), 0);
        repeat (3) tick();
        rst = 1'b1;
        repeat (2) tick();

        // Exact latency of a 6-cycle coin: sensor sampled high R1..R6.
        en = 1'b1;
        sensor = 1'b1;
        repeat (6) tick();
        sensor = 1'b0;
        tick();
        tick();
        chk("lat_coin_pre", int'(coin), 0);
        tick();
        chk("lat_coin", int'(coin), 5);
        chk("lat_busy_on", int'(busy), 1);
        tick();
        chk("lat_coin_post", int'(coin), 0);
        repeat (4) tick();
        chk("lat_busy_hold", int'(busy), 1);
        tick();
        chk("lat_busy_off", int'(busy), 0);
        repeat (4) tick();

        for (int i = 0; i < 16; i++) run_vec(i);

        // Jam: s high from R3, cnt reaches 100 at R102.
        en = 1'b1;
        c0 = n_coin;
        r0 = n_rej;
        sensor = 1'b1;
        for (int i = 1; i <= 150; i++) begin
            tick();
            if (i == 101) chk("jam_early", int'(jam), 0);
            if (i == 102) chk("jam_rise", int'(jam), 1);
        end
        chk("jam_hold", int'(jam), 1);
        sensor = 1'b0;
        tick();
        tick();
        chk("jam_pre_fall", int'(jam), 1);
        chk("jam_pre_rej", int'(reject), 0);
        tick();
        chk("jam_fall", int'(jam), 0);
        chk("jam_rej", int'(reject), 1);
        repeat (10) tick();
        chk("jam_ncoin", n_coin - c0, 0);
        chk("jam_nrej", n_rej - r0, 1);
        chk("jam_busy", int'(busy), 0);

        // Bounce: 6 high, 2 low, 3 high; idle after 5 lows past the bounce.
        c0 = n_coin;
        s0 = coin_sum;
        r0 = n_rej;
        sensor = 1'b1;
        repeat (6) tick();
        sensor = 1'b0;
        repeat (2) tick();
        sensor = 1'b1;
        repeat (3) tick();
        sensor = 1'b0;
        repeat (7) tick();
        chk("bnc_busy_hold", int'(busy), 1);
        tick();
        chk("bnc_busy_off", int'(busy), 0);
        repeat (10) tick();
        chk("bnc_ncoin", n_coin - c0, 1);
        chk("bnc_sum", coin_sum - s0, 5);
        chk("bnc_nrej", n_rej - r0, 0);

        // Reset mid-measurement.
        c0 = n_coin;
        r0 = n_rej;
        sensor = 1'b1;
        repeat (6) tick();
        chk("mrst_busy_pre", int'(busy), 1);
        rst = 1'b0;
        #1;
        chk("mrst_coin", int'(coin), 0);
        chk("mrst_reject", int'(reject), 0);
        chk("mrst_jam", int'(jam), 0);
        chk("mrst_busy", int'(busy), 0);
        tick();
        sensor = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        repeat (20) tick();
        chk("mrst_ncoin", n_coin - c0, 0);
        chk("mrst_nrej", n_rej - r0, 0);
        chk("mrst_busy_after", int'(busy), 0);

        chk("excl", n_excl, 0);
        chk("coin_values", n_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
